// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned IsaWidth       = 32;
  localparam logic [31:0] DefaultResetPc = 32'h8000_0000;
  localparam int unsigned PcStep         = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: issues one SRAM read per instruction, captures the returned word and
// presents {pc, inst} to the decoder over valid/ready; redirects squash anything in flight.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IsaWidth,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc),
  parameter int unsigned       CNT_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    cnt_d       = cnt_q;
    // Redirect wins over everything, including a same-cycle handshake in HOLD.
    if (redirect_valid) begin
      pc_d        = redirect_pc & ~ADDR_W'(3);
      out_valid_d = 1'b0;
      state_d     = fetch_en ? StReq : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fetch_en) state_d = StReq;
        end
        StReq: begin
          state_d = StWait;
        end
        StWait: begin
          out_inst_d  = mem_rdata;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          state_d     = StHold;
        end
        StHold: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            pc_d        = pc_q + ADDR_W'(PcStep);
            cnt_d       = cnt_q + CNT_W'(1);
            state_d     = fetch_en ? StReq : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    mem_ren   = (state_q == StReq);
    mem_raddr = pc_q;
    out_valid = out_valid_q;
    out_inst  = out_inst_q;
    out_pc    = out_pc_q;
    fetch_cnt = cnt_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: 1-cycle SRAM model, scoreboard of expected {pc, inst} popped on each
// decoder handshake, plus directed checks of request/redirect/halt/reset behaviour.
module tb_ifu_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [63:0] fetch_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];

  ifu_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .mem_ren        (mem_ren),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] addr);
    if (addr == 32'h8000_0000) return 32'h0000_0413;
    if (addr == 32'h8000_0004) return 32'h0000_0513;
    return {addr[23:0], 8'h13};
  endfunction

  // SRAM model: data valid the cycle after the read; garbage otherwise so stale capture shows.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_fn(mem_raddr);
    else         mem_rdata <= 32'hdead_beef;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_fn(pc);
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A handshake completes at the next posedge when valid&ready hold and no redirect squashes it.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'(out_pc), 64'hffff_ffff_ffff_ffff);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", 64'(out_pc), 64'(e.pc));
        check("sb_inst", 64'(out_inst), 64'(e.inst));
      end
    end
  end

  initial begin
    reset          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_inst", 64'(out_inst), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_cnt", fetch_cnt, 64'd0);
    check("rst_ren", 64'(mem_ren), 64'd0);
    check("rst_raddr", 64'(mem_raddr), 64'h8000_0000);

    // 1: first fetch after release
    reset     = 1'b1;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    push(32'h8000_0000);
    check("s1_idle_ren", 64'(mem_ren), 64'd0);
    step();
    check("s1_req_ren", 64'(mem_ren), 64'd1);
    check("s1_req_addr", 64'(mem_raddr), 64'h8000_0000);
    step();
    check("s1_wait_ren", 64'(mem_ren), 64'd0);
    check("s1_wait_valid", 64'(out_valid), 64'd0);
    step();
    check("s1_hold_valid", 64'(out_valid), 64'd1);
    step();
    check("s1_cnt", fetch_cnt, 64'd1);
    check("s1_next_ren", 64'(mem_ren), 64'd1);
    check("s1_next_addr", 64'(mem_raddr), 64'h8000_0004);

    // 2: backpressure in HOLD
    out_ready = 1'b0;
    push(32'h8000_0004);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("s2_valid", 64'(out_valid), 64'd1);
      check("s2_inst", 64'(out_inst), 64'h0000_0513);
      check("s2_pc", 64'(out_pc), 64'h8000_0004);
      check("s2_ren", 64'(mem_ren), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("s2_cnt", fetch_cnt, 64'd2);
    check("s2_valid_drop", 64'(out_valid), 64'd0);
    check("s2_next_addr", 64'(mem_raddr), 64'h8000_0008);

    // 3: redirect during WAIT
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    step();
    redirect_valid = 1'b0;
    check("s3_ren", 64'(mem_ren), 64'd1);
    check("s3_addr", 64'(mem_raddr), 64'h8000_0100);
    check("s3_valid", 64'(out_valid), 64'd0);
    check("s3_cnt", fetch_cnt, 64'd2);
    push(32'h8000_0100);
    step();
    step();
    check("s3_hold_valid", 64'(out_valid), 64'd1);
    step();
    check("s3_cnt_after", fetch_cnt, 64'd3);

    // 4: redirect with ready in HOLD squashes the held instruction
    out_ready = 1'b0;
    step();
    step();
    check("s4_hold_valid", 64'(out_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check("s4_cnt", fetch_cnt, 64'd3);
    check("s4_valid", 64'(out_valid), 64'd0);
    check("s4_ren", 64'(mem_ren), 64'd1);
    check("s4_addr", 64'(mem_raddr), 64'h8000_0200);

    // 5: fetch_en drops during WAIT
    push(32'h8000_0200);
    step();
    fetch_en = 1'b0;
    step();
    check("s5_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("s5_cnt", fetch_cnt, 64'd4);
    check("s5_idle_ren", 64'(mem_ren), 64'd0);
    check("s5_addr", 64'(mem_raddr), 64'h8000_0204);
    for (int i = 0; i < 2; i++) begin
      step();
      check("s5_park_ren", 64'(mem_ren), 64'd0);
    end
    fetch_en = 1'b1;
    step();
    check("s5_resume_ren", 64'(mem_ren), 64'd1);
    check("s5_resume_addr", 64'(mem_raddr), 64'h8000_0204);
    step();
    step();
    check("s5_resume_valid", 64'(out_valid), 64'd1);

    // 6: async reset in HOLD, held instruction never handed over
    #2;
    reset = 1'b0;
    #1;
    check("s6_valid", 64'(out_valid), 64'd0);
    check("s6_cnt", fetch_cnt, 64'd0);
    check("s6_addr", 64'(mem_raddr), 64'h8000_0000);
    check("s6_ren", 64'(mem_ren), 64'd0);
    sb_q.delete();
    step();
    reset     = 1'b1;
    out_ready = 1'b1;
    push(32'h8000_0000);
    step();
    check("s6_req_ren", 64'(mem_ren), 64'd1);
    check("s6_req_addr", 64'(mem_raddr), 64'h8000_0000);
    step();
    step();
    check("s6_hold_valid", 64'(out_valid), 64'd1);
    check("s6_inst", 64'(out_inst), 64'h0000_0413);
    step();
    check("s6_cnt", fetch_cnt, 64'd1);
    check("s6_next_addr", 64'(mem_raddr), 64'h8000_0004);

    // Redirect during REQ to the top word: alignment and pc wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_ffff;
    step();
    redirect_valid = 1'b0;
    check("wr_ren", 64'(mem_ren), 64'd1);
    check("wr_addr", 64'(mem_raddr), 64'hffff_fffc);
    push(32'hffff_fffc);
    step();
    step();
    check("wr_hold_valid", 64'(out_valid), 64'd1);
    fetch_en = 1'b0;
    step();
    check("wr_wrap_addr", 64'(mem_raddr), 64'h0000_0000);
    check("wr_cnt", fetch_cnt, 64'd2);
    check("wr_idle_ren", 64'(mem_ren), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
